cdb_result_buffer: RTL and testbench
====================================

# cdb_result_buffer

Per-functional-unit result buffering and round-robin arbitration stage directly upstream of the common data bus. Each FU (ALU, MULT, LSU, BTU lanes) pushes completed results (value, ROB tag, branch resolution) into its own small FIFO. Every cycle the block presents at most one FIFO head to the CDB as a one-hot `fu_result_ready`, so the CDB's priority select always picks the lane chosen here. Result: no FU result is lost or starved, and the CDB stays purely combinational.

## Interface
Parameters:
- `FU_NUM`, 4: number of FU lanes; fixed at 4 to match the CDB input width.
- `DEPTH`, 2: entries per lane FIFO; power of two, ≥ 2.
- `BTU_IDX`, 3: lane index carrying branch results; must equal the CDB's BTU select code.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash all buffered results (ROB mispredict recovery).
- `fu_valid`  in  [FU_NUM]  lane i presents a result this cycle.
- `fu_value`  in  [FU_NUM][`XLEN`]  result values.
- `fu_tag`  in  [FU_NUM][`ROB_TAG_LEN`]  destination ROB tags.
- `btu_mis_predict`  in  1  branch mispredict flag; sampled only with lane BTU_IDX.
- `btu_target_pc`  in  `XLEN`  resolved branch target; sampled only with lane BTU_IDX.
- `fu_ready`  out  [FU_NUM]  lane i FIFO can accept a push this cycle.
- `fu_results`  out  [FU_NUM][`XLEN`]  value to CDB; only the granted lane is nonzero.
- `fu_result_ready`  out  [FU_NUM]  one-hot grant to CDB, or all zero.
- `fu_tags`  out  [FU_NUM][`ROB_TAG_LEN`]  tag to CDB; only the granted lane is nonzero.
- `fu_mis_predict`  out  1  mispredict flag of the granted BTU entry, else 0.
- `fu_target_pc`  out  `XLEN`  target PC of the granted BTU entry, else 0.

## Operation
- State per lane: FIFO storage of {value, tag}, plus {mis_predict, target_pc} for lane BTU_IDX only. Also `head` ptr, `tail` ptr, and `count` (0..DEPTH).
- Global state: `rr_ptr`, width $clog2(FU_NUM), the lane with highest grant priority.
- Ready: `fu_ready[i] = (count[i] < DEPTH) & ~reset & ~flush`.
  - Conservative: a same-cycle pop does not grant extra credit.
- Push: when `fu_valid[i] & fu_ready[i]`, write at `tail`, `tail++` (wraps mod DEPTH), `count++`.
  - `fu_valid` with `fu_ready=0` is dropped. It is an FU protocol error, and the bench flags it.
- Grant (combinational from registered state):
  - Scan lanes `rr_ptr, rr_ptr+1, …` mod FU_NUM; the first with `count>0` is granted.
  - No non-empty lane → no grant.
  - `reset` or `flush` high → no grant.
- Output:
  - Granted lane g drives its head value/tag on `fu_results[g]`/`fu_tags[g]` and sets `fu_result_ready[g]`.
  - All other lanes output 0.
  - `fu_mis_predict`/`fu_target_pc` carry the head's branch fields only when g == BTU_IDX, else 0.
- Pop: the CDB consumes unconditionally, so the granted lane does `head++` (wrap) and `count--` at the edge.
  - `rr_ptr <= (g+1) mod FU_NUM`. `rr_ptr` is unchanged when there is no grant.
- Simultaneous push and pop on one lane: `count` unchanged; both pointers advance.
- Flush: all `count`, `head`, `tail` ← 0; `rr_ptr` ← 0. Pushes presented in the flush cycle are discarded.
- Reset: same as flush. Storage contents don't care.

## Timing
- While `reset` is high, and for the cycle after: all outputs 0 and `fu_ready` reflects `count=0`.
  - Exception: `fu_ready` is 0 while `reset` is asserted.
- Latency: push accepted at edge N → earliest `fu_result_ready` in cycle N+1 (no input bypass).
- Throughput: one result per cycle total. Each lane sustains one per FU_NUM cycles under full contention.
- Fairness: a non-empty lane is granted within FU_NUM cycles.
- Boundary cases:
  - Full lane with a grant: `fu_ready=0` this cycle, 1 next cycle.
  - Empty lane: never granted.
  - Pointer wrap DEPTH-1→0: must preserve FIFO order.

## Test plan
- Single ALU result: reset 2 cycles, push lane 0 value 0x11 tag 5 at cycle 3 → cycle 4 `fu_result_ready=4'b0001`, `fu_results[0]=0x11`, `fu_tags[0]=5`; cycle 5 all zero.
- Contention: push lanes 0–3 (values 0xA0–0xA3) in the same cycle with `rr_ptr=0` → grants one per cycle in order 0,1,2,3; `rr_ptr` ends at 0.
- Backpressure/wrap: push lane 1 three cycles straight (0x1,0x2,0x3) while lane 0 holds continuous traffic → `fu_ready[1]` drops after 2 entries. Lane 1 outputs 0x1,0x2,0x3 in order with no drop.
- Branch: push BTU lane tag 9, `btu_mis_predict=1`, target 0x400 → grant cycle shows `fu_mis_predict=1`, `fu_target_pc=0x400`. A concurrently granted ALU cycle shows both 0.
- Flush mid-stream: 3 lanes holding entries, assert `flush` with a simultaneous push → that cycle no grant. Next cycle all `count=0`, no `fu_result_ready`, `fu_ready=4'b1111`.
- Reset mid-operation: full lanes, assert `reset` 1 cycle → outputs 0 and `fu_ready=0` during reset. Afterwards empty, `rr_ptr=0`, and the next push is granted after 1 cycle.

Source files
------------

// File: rtl/cdb_result_buffer.sv
// Per-FU result FIFOs with round-robin selection of one head per cycle for the CDB.
// The grant is one-hot, and only the granted lane drives nonzero value/tag so the CDB can stay purely combinational.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_result_buffer #(
  parameter int FU_NUM  = 4,
  parameter int DEPTH   = 2,
  parameter int BTU_IDX = 3
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [FU_NUM-1:0]                      fu_valid,
  input  logic [FU_NUM-1:0][`XLEN-1:0]           fu_value,
  input  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0]    fu_tag,
  input  logic                                   btu_mis_predict,
  input  logic [`XLEN-1:0]                       btu_target_pc,
  output logic [FU_NUM-1:0]                      fu_ready,
  output logic [FU_NUM-1:0][`XLEN-1:0]           fu_results,
  output logic [FU_NUM-1:0]                      fu_result_ready,
  output logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0]    fu_tags,
  output logic                                   fu_mis_predict,
  output logic [`XLEN-1:0]                       fu_target_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RR_W  = $clog2(FU_NUM);

  logic [`XLEN-1:0]        val_mem [FU_NUM][DEPTH];
  logic [`ROB_TAG_LEN-1:0] tag_mem [FU_NUM][DEPTH];
  logic                    mis_mem [DEPTH];
  logic [`XLEN-1:0]        pc_mem  [DEPTH];
  logic [PTR_W-1:0]        head    [FU_NUM];
  logic [PTR_W-1:0]        tail    [FU_NUM];
  logic [CNT_W-1:0]        count   [FU_NUM];
  logic [RR_W-1:0]         rr_ptr;
  logic [FU_NUM-1:0]       push;
  logic [FU_NUM-1:0]       grant;
  logic [RR_W-1:0]         grant_idx;
  logic                    grant_any;

  // Ready credit ignores a same-cycle pop, so a full lane stays closed for one cycle.
  always_comb begin
    fu_ready = '0;
    push     = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      fu_ready[i] = (count[i] < CNT_W'(DEPTH)) & ~reset & ~flush;
      push[i]     = fu_valid[i] & fu_ready[i];
    end
  end

  // Round-robin scan starting at rr_ptr; first non-empty lane wins.
  always_comb begin
    logic [RR_W-1:0] lane;
    logic            hit;
    lane      = '0;
    hit       = 1'b0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < FU_NUM; k++) begin
      lane      = RR_W'((32'(rr_ptr) + k) % FU_NUM);
      hit       = ~grant_any & (count[lane] != '0);
      grant_idx = hit ? lane : grant_idx;
      grant_any = grant_any | hit;
    end
    grant_any = grant_any & ~reset & ~flush;
    grant     = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      grant[i] = grant_any & (grant_idx == RR_W'(i));
    end
  end

  // Only the granted lane's head reaches the bus; everything else is forced to zero.
  always_comb begin
    fu_results      = '0;
    fu_tags         = '0;
    fu_result_ready = grant;
    for (int i = 0; i < FU_NUM; i++) begin
      fu_results[i] = grant[i] ? val_mem[i][head[i]] : '0;
      fu_tags[i]    = grant[i] ? tag_mem[i][head[i]] : '0;
    end
    fu_mis_predict = grant[BTU_IDX] & mis_mem[head[BTU_IDX]];
    fu_target_pc   = grant[BTU_IDX] ? pc_mem[head[BTU_IDX]] : '0;
  end

  // FIFO pointers, occupancy and arbitration pointer; flush behaves like reset.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < FU_NUM; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < FU_NUM; i++) begin
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push[i]) begin
          tail[i] <= tail[i] + PTR_W'(1);
        end
        if (grant[i]) begin
          head[i] <= head[i] + PTR_W'(1);
        end
        case ({push[i], grant[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
      if (grant_any) begin
        rr_ptr <= RR_W'((32'(grant_idx) + 1) % FU_NUM);
      end
    end
  end

  // Payload storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    for (int i = 0; i < FU_NUM; i++) begin
      if (push[i]) begin
        val_mem[i][tail[i]] <= fu_value[i];
        tag_mem[i][tail[i]] <= fu_tag[i];
      end
    end
    if (push[BTU_IDX]) begin
      mis_mem[tail[BTU_IDX]] <= btu_mis_predict;
      pc_mem[tail[BTU_IDX]]  <= btu_target_pc;
    end
  end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Directed bench for cdb_result_buffer: stimulus queues hand-computed grants (lane, payload, cycle)
// and a negedge monitor pops and compares them, plus idle/ready expectations flagged by stimulus.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_cdb_result_buffer;
  localparam int FU_NUM  = 4;
  localparam int DEPTH   = 2;
  localparam int BTU_IDX = 3;

  logic                                clock = 1'b0;
  logic                                reset;
  logic                                flush;
  logic [FU_NUM-1:0]                   fu_valid;
  logic [FU_NUM-1:0][`XLEN-1:0]        fu_value;
  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0] fu_tag;
  logic                                btu_mis_predict;
  logic [`XLEN-1:0]                    btu_target_pc;
  logic [FU_NUM-1:0]                   fu_ready;
  logic [FU_NUM-1:0][`XLEN-1:0]        fu_results;
  logic [FU_NUM-1:0]                   fu_result_ready;
  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0] fu_tags;
  logic                                fu_mis_predict;
  logic [`XLEN-1:0]                    fu_target_pc;

  cdb_result_buffer #(.FU_NUM(FU_NUM), .DEPTH(DEPTH), .BTU_IDX(BTU_IDX)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_value(fu_value), .fu_tag(fu_tag),
    .btu_mis_predict(btu_mis_predict), .btu_target_pc(btu_target_pc),
    .fu_ready(fu_ready), .fu_results(fu_results), .fu_result_ready(fu_result_ready),
    .fu_tags(fu_tags), .fu_mis_predict(fu_mis_predict), .fu_target_pc(fu_target_pc)
  );

  typedef struct {
    int                      lane;
    logic [`XLEN-1:0]        val;
    logic [`ROB_TAG_LEN-1:0] tag;
    logic                    mis;
    logic [`XLEN-1:0]        pc;
    int                      cyc;
  } sb_t;

  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic       exp_idle;
  logic       exp_ready_on;
  logic [3:0] exp_ready_mask;
  logic [3:0] exp_ready_val;
  logic       done = 1'b0;
  logic       done_chk = 1'b0;

  sb_t                                 e;
  logic [FU_NUM-1:0][`XLEN-1:0]        er;
  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0] et;
  logic [FU_NUM-1:0]                   eg;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, want);
    end
  endtask

  // Monitor: scoreboard pops on every grant, plus stimulus-flagged idle/ready checks.
  always @(negedge clock) begin
    if (|fu_result_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_grant at cycle %0d: got fu_result_ready=%b, expected none", cyc, fu_result_ready);
      end else begin
        e  = sb.pop_front();
        er = '0;
        et = '0;
        eg = '0;
        eg[e.lane] = 1'b1;
        er[e.lane] = e.val;
        et[e.lane] = e.tag;
        cmp("grant_onehot", 128'(fu_result_ready), 128'(eg));
        cmp("grant_cycle", 128'(cyc), 128'(e.cyc));
        cmp("results", 128'(fu_results), 128'(er));
        cmp("tags", 128'(fu_tags), 128'(et));
        cmp("mis_predict", 128'(fu_mis_predict), 128'(e.mis));
        cmp("target_pc", 128'(fu_target_pc), 128'(e.pc));
      end
    end
    if (exp_idle) begin
      cmp("idle_grant", 128'(fu_result_ready), 128'(4'b0000));
      cmp("idle_results", 128'(fu_results), 128'(0));
      cmp("idle_tags", 128'(fu_tags), 128'(0));
      cmp("idle_branch", 128'({fu_mis_predict, fu_target_pc}), 128'(0));
    end
    if (exp_ready_on) begin
      cmp("fu_ready", 128'(fu_ready & exp_ready_mask), 128'(exp_ready_val & exp_ready_mask));
    end
    for (int i = 0; i < FU_NUM; i++) begin
      if (fu_valid[i] && !reset && !flush) begin
        cmp("ready_on_valid", 128'(fu_ready[i]), 128'(1'b1));
      end
    end
    if (done && !done_chk) begin
      done_chk <= 1'b1;
      cmp("scoreboard_drained", 128'(sb.size()), 128'(0));
    end
  end

  task automatic clr();
    fu_valid        = '0;
    fu_value        = '0;
    fu_tag          = '0;
    btu_mis_predict = 1'b0;
    btu_target_pc   = '0;
    exp_idle        = 1'b0;
    exp_ready_on    = 1'b0;
    exp_ready_mask  = 4'b0000;
    exp_ready_val   = 4'b0000;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clr();
  endtask

  task automatic push_in(input int l, input logic [31:0] v, input logic [5:0] t);
    fu_valid[l] = 1'b1;
    fu_value[l] = v;
    fu_tag[l]   = t;
  endtask

  task automatic sb_push(input int l, input logic [31:0] v, input logic [5:0] t,
                         input logic m, input logic [31:0] pc, input int c);
    sb_t s;
    s.lane = l; s.val = v; s.tag = t; s.mis = m; s.pc = pc; s.cyc = c;
    sb.push_back(s);
  endtask

  task automatic want_ready(input logic [3:0] mask, input logic [3:0] val);
    exp_ready_on   = 1'b1;
    exp_ready_mask = mask;
    exp_ready_val  = val;
  endtask

  initial begin
    int c;
    reset = 1'b1;
    flush = 1'b0;
    clr();

    // Reset held over two edges; outputs idle and fu_ready low throughout.
    tick();
    exp_idle = 1'b1;
    want_ready(4'b1111, 4'b0000);
    tick();
    reset = 1'b0;
    exp_idle = 1'b1;
    want_ready(4'b1111, 4'b1111);

    // Single ALU result: granted exactly one cycle after acceptance, then idle.
    push_in(0, 32'h11, 6'd5);
    sb_push(0, 32'h11, 6'd5, 1'b0, 32'h0, cyc + 1);
    tick();
    tick();
    exp_idle = 1'b1;
    tick();

    // Flush an empty buffer to bring rr_ptr back to 0, then full contention.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      push_in(i, 32'hA0 + 32'(i), 6'(i + 1));
      sb_push(i, 32'hA0 + 32'(i), 6'(i + 1), 1'b0, 32'h0, c + 1 + i);
    end
    tick();
    repeat (4) tick();

    // rr_ptr must be back at 0: lane 0 beats lane 1.
    c = cyc;
    push_in(1, 32'hA5, 6'd7);
    push_in(0, 32'hA4, 6'd6);
    sb_push(0, 32'hA4, 6'd6, 1'b0, 32'h0, c + 1);
    sb_push(1, 32'hA5, 6'd7, 1'b0, 32'h0, c + 2);
    tick();
    tick();
    tick();

    // Backpressure and wrap on lane 1 against continuous lane 0 traffic (rr_ptr starts at 2).
    c = cyc;
    sb_push(0, 32'h100, 6'h10, 1'b0, 32'h0, c + 1);
    sb_push(1, 32'h1,   6'h21, 1'b0, 32'h0, c + 2);
    sb_push(0, 32'h101, 6'h11, 1'b0, 32'h0, c + 3);
    sb_push(1, 32'h2,   6'h22, 1'b0, 32'h0, c + 4);
    sb_push(0, 32'h102, 6'h12, 1'b0, 32'h0, c + 5);
    sb_push(1, 32'h3,   6'h23, 1'b0, 32'h0, c + 6);
    sb_push(0, 32'h103, 6'h13, 1'b0, 32'h0, c + 7);
    push_in(0, 32'h100, 6'h10);
    push_in(1, 32'h1, 6'h21);
    tick();
    push_in(0, 32'h101, 6'h11);
    push_in(1, 32'h2, 6'h22);
    tick();
    push_in(0, 32'h102, 6'h12);
    want_ready(4'b0010, 4'b0000);
    tick();
    push_in(1, 32'h3, 6'h23);
    want_ready(4'b0011, 4'b0010);
    tick();
    push_in(0, 32'h103, 6'h13);
    tick();
    repeat (3) tick();

    // Branch lane (rr_ptr at 1): BTU granted first with its branch fields, ALU after with zeros.
    c = cyc;
    push_in(3, 32'h77, 6'd9);
    btu_mis_predict = 1'b1;
    btu_target_pc   = 32'h400;
    push_in(0, 32'h55, 6'd4);
    sb_push(3, 32'h77, 6'd9, 1'b1, 32'h400, c + 1);
    sb_push(0, 32'h55, 6'd4, 1'b0, 32'h0,   c + 2);
    tick();
    tick();
    tick();

    // Flush with three lanes loaded and a concurrent push on lane 3.
    push_in(0, 32'hB0, 6'd30);
    push_in(1, 32'hB1, 6'd31);
    push_in(2, 32'hB2, 6'd32);
    tick();
    flush = 1'b1;
    push_in(3, 32'hB3, 6'd33);
    exp_idle = 1'b1;
    want_ready(4'b1111, 4'b0000);
    tick();
    flush = 1'b0;
    exp_idle = 1'b1;
    want_ready(4'b1111, 4'b1111);
    tick();
    exp_idle = 1'b1;
    c = cyc;
    push_in(3, 32'hB4, 6'd34);
    push_in(0, 32'hB5, 6'd35);
    sb_push(0, 32'hB5, 6'd35, 1'b0, 32'h0, c + 1);
    sb_push(3, 32'hB4, 6'd34, 1'b0, 32'h0, c + 2);
    tick();
    tick();
    tick();

    // Reset mid-operation with lanes full; rr_ptr is 1 before reset and must return to 0.
    c = cyc;
    for (int i = 0; i < 4; i++) push_in(i, 32'hC0 + 32'(i), 6'(40 + i));
    sb_push(0, 32'hC0, 6'd40, 1'b0, 32'h0, c + 1);
    tick();
    for (int i = 0; i < 4; i++) push_in(i, 32'hD0 + 32'(i), 6'(50 + i));
    tick();
    reset = 1'b1;
    exp_idle = 1'b1;
    want_ready(4'b1111, 4'b0000);
    tick();
    reset = 1'b0;
    exp_idle = 1'b1;
    want_ready(4'b1111, 4'b1111);
    c = cyc;
    push_in(1, 32'hE1, 6'd61);
    push_in(0, 32'hE0, 6'd60);
    sb_push(0, 32'hE0, 6'd60, 1'b0, 32'h0, c + 1);
    sb_push(1, 32'hE1, 6'd61, 1'b0, 32'h0, c + 2);
    tick();
    repeat (3) tick();

    done = 1'b1;
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
